// File: rtl/control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// control_fsm_pkg
// Shared definitions for the multi-cycle controller and its 16-bit datapath:
// state encoding, opcode constants, ALU operation and PC source codes, and a
// helper that classifies an opcode into the instruction family that DECODE
// dispatches on.
// -----------------------------------------------------------------------------
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  // Opcode values as found in instr[15:12].
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JUMP = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS1  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_MEM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_R;
      OP_ADDI:                       cls = CLS_I;
      OP_LW, OP_SW:                  cls = CLS_MEM;
      OP_BEQ:                        cls = CLS_BRANCH;
      OP_JUMP:                       cls = CLS_JUMP;
      OP_HALT:                       cls = CLS_HALT;
      default:                       cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// -----------------------------------------------------------------------------
// control_fsm_if
// Bundle between the controller and the datapath.
//   opcode, zero, mem_ready : status from datapath / memory into the controller
//   pc_w .. rf_w            : register write strobes
//   mem_rd, mem_wr          : memory requests
//   alu_op, pc_src, halted  : datapath steering and halt indication
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface control_fsm_if #(
  parameter int OPCODE_W = 4
);
  import control_fsm_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic    pc_w;
  logic    ir_w;
  logic    a_w;
  logic    b_w;
  logic    aluout_w;
  logic    mdr_w;
  logic    rf_w;
  logic    mem_rd;
  logic    mem_wr;
  alu_op_t alu_op;
  pc_src_t pc_src;
  logic    halted;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_w, ir_w, a_w, b_w, aluout_w, mdr_w, rf_w,
    output mem_rd, mem_wr, alu_op, pc_src, halted
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_w, ir_w, a_w, b_w, aluout_w, mdr_w, rf_w,
    input  mem_rd, mem_wr, alu_op, pc_src, halted
  );

endinterface

// File: rtl/control_decode.sv
// -----------------------------------------------------------------------------
// control_decode
// Purely combinational strobe decode of the current controller state.
//   state, op, zero, mem_ready : current state and qualifiers
//   active                     : low while reset is held; forces every output
//                                to 0 so nothing (including mem_rd) leaks out
//   pc_w .. halted             : strobes and steering codes
// -----------------------------------------------------------------------------
module control_decode
  import control_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       active,
  output logic       pc_w,
  output logic       ir_w,
  output logic       a_w,
  output logic       b_w,
  output logic       aluout_w,
  output logic       mdr_w,
  output logic       rf_w,
  output logic       mem_rd,
  output logic       mem_wr,
  output alu_op_t    alu_op,
  output pc_src_t    pc_src,
  output logic       halted
);

  always_comb begin
    pc_w     = 1'b0;
    ir_w     = 1'b0;
    a_w      = 1'b0;
    b_w      = 1'b0;
    aluout_w = 1'b0;
    mdr_w    = 1'b0;
    rf_w     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    alu_op   = ALU_ADD;
    pc_src   = PC_PLUS1;
    halted   = 1'b0;
    if (active) begin
      case (state)
        S_FETCH: begin
          mem_rd = 1'b1;
          // IR load and PC+1 happen only in the cycle the read completes.
          ir_w   = mem_ready;
          pc_w   = mem_ready;
        end
        S_DECODE: begin
          a_w      = 1'b1;
          b_w      = 1'b1;
          aluout_w = 1'b1;   // branch target precompute, ALU adds PC+offset
        end
        S_EXEC_R: begin
          alu_op   = alu_op_t'(op[1:0]);
          aluout_w = 1'b1;
        end
        S_EXEC_I, S_MEM_ADDR: aluout_w = 1'b1;
        S_R_WB, S_MEM_WB:     rf_w = 1'b1;
        S_MEM_RD: begin
          mem_rd = 1'b1;
          mdr_w  = mem_ready;
        end
        S_MEM_WR: mem_wr = 1'b1;
        S_BRANCH: begin
          alu_op = ALU_SUB;
          pc_w   = zero;
          pc_src = PC_BRANCH;
        end
        S_JUMP: begin
          pc_w   = 1'b1;
          pc_src = PC_JUMP;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Multi-cycle instruction sequencer for the 16-bit datapath.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, returns the sequencer to FETCH
//   bus   : controller side of control_fsm_if (status in, strobes out)
//   state : current state, for observation by the datapath / debug
// -----------------------------------------------------------------------------
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  control_fsm_if.master      bus,
  output state_t             state
);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] op;

  // Opcode map is defined on four bits; wider/narrower fields are adapted here.
  assign op    = 4'(bus.opcode);
  assign state = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (classify(op))
          CLS_R:      state_next = S_EXEC_R;
          CLS_I:      state_next = S_EXEC_I;
          CLS_MEM:    state_next = S_MEM_ADDR;
          CLS_BRANCH: state_next = S_BRANCH;
          CLS_JUMP:   state_next = S_JUMP;
          CLS_HALT:   state_next = S_HALT;
          default:    state_next = S_FETCH;   // illegal opcode behaves as NOP
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_R_WB;
      S_R_WB:             state_next = S_FETCH;
      S_MEM_ADDR: begin
        if (op == OP_LW)      state_next = S_MEM_RD;
        else if (op == OP_SW) state_next = S_MEM_WR;
        else                  state_next = S_FETCH;
      end
      S_MEM_RD: if (bus.mem_ready) state_next = S_MEM_WB;
      S_MEM_WB: state_next = S_FETCH;
      S_MEM_WR: if (bus.mem_ready) state_next = S_FETCH;
      S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;   // unused encodings recover
    endcase
  end

  control_decode u_decode (
    .state     (state_reg),
    .op        (op),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .active    (rst_n),
    .pc_w      (bus.pc_w),
    .ir_w      (bus.ir_w),
    .a_w       (bus.a_w),
    .b_w       (bus.b_w),
    .aluout_w  (bus.aluout_w),
    .mdr_w     (bus.mdr_w),
    .rf_w      (bus.rf_w),
    .mem_rd    (bus.mem_rd),
    .mem_wr    (bus.mem_wr),
    .alu_op    (bus.alu_op),
    .pc_src    (bus.pc_src),
    .halted    (bus.halted)
  );

endmodule
